// File: rtl/profcounter_pkg.sv
// ----------------------------------------------------------------------------
// profcounter_pkg : shared FSM encoding, AXI codes and helpers for the
//                   profiling-counter log flush path.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package profcounter_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int LOG_WORD_BYTES = 4;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } log_word_t;

  // Byte address of log word idx; wraps modulo 2^64 by construction.
  function automatic logic [63:0] word_addr(input logic [63:0] base,
                                            input logic [63:0] idx);
    return base + (idx * 64'(LOG_WORD_BYTES));
  endfunction

endpackage

`default_nettype wire

// File: rtl/log_flush_sequencer_if.sv
// ----------------------------------------------------------------------------
// log_flush_sequencer_if : AXI4 write-channel subset used by the log flush
//                          master (AW, W, B only).   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface log_flush_sequencer_if;

  logic [63:0] axiAWADDR;
  logic        axiAWVALID;
  logic        axiAWREADY;
  logic [31:0] axiWDATA;
  logic [3:0]  axiWSTRB;
  logic        axiWVALID;
  logic        axiWREADY;
  logic [1:0]  axiBRESP;
  logic        axiBVALID;
  logic        axiBREADY;

  modport master (
    output axiAWADDR, axiAWVALID,
    input  axiAWREADY,
    output axiWDATA, axiWSTRB, axiWVALID,
    input  axiWREADY,
    input  axiBRESP, axiBVALID,
    output axiBREADY
  );

  modport slave (
    input  axiAWADDR, axiAWVALID,
    output axiAWREADY,
    input  axiWDATA, axiWSTRB, axiWVALID,
    output axiWREADY,
    output axiBRESP, axiBVALID,
    input  axiBREADY
  );

endinterface

`default_nettype wire

// File: rtl/log_flush_sequencer_axi_single_write.sv
// ----------------------------------------------------------------------------
// axi_single_write : issues one single-beat AW+W write and waits for its B
//                    response, tracking each channel handshake separately. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_single_write
  import profcounter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      go_i,
  input  log_word_t word_i,
  output logic      issued_o,
  output logic      resp_o,
  output logic      resp_err_o,
  log_flush_sequencer_if.master axi
);

  logic      awvalid_q;
  logic      wvalid_q;
  logic      issuing_q;
  logic      bwait_q;
  log_word_t word_q;

  logic aw_ok;
  logic w_ok;

  // A channel counts as complete once its handshake has happened or is happening now.
  assign aw_ok      = ~awvalid_q | axi.axiAWREADY;
  assign w_ok       = ~wvalid_q  | axi.axiWREADY;
  assign issued_o   = issuing_q & aw_ok & w_ok;
  assign resp_o     = bwait_q & axi.axiBVALID;
  assign resp_err_o = resp_o & (axi.axiBRESP != AXI_RESP_OKAY);

  assign axi.axiAWADDR  = word_q.addr;
  assign axi.axiAWVALID = awvalid_q;
  assign axi.axiWDATA   = word_q.data;
  assign axi.axiWSTRB   = 4'hF;
  assign axi.axiWVALID  = wvalid_q;
  assign axi.axiBREADY  = bwait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      issuing_q <= 1'b0;
      bwait_q   <= 1'b0;
      word_q    <= '0;
    end else begin
      if (go_i) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        issuing_q <= 1'b1;
        word_q    <= word_i;
      end else if (issuing_q) begin
        if (axi.axiAWREADY) awvalid_q <= 1'b0;
        if (axi.axiWREADY)  wvalid_q  <= 1'b0;
        if (issued_o) begin
          issuing_q <= 1'b0;
          bwait_q   <= 1'b1;
        end
      end
      if (resp_o) bwait_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/log_flush_sequencer.sv
// ----------------------------------------------------------------------------
// log_flush_sequencer : on each start, freezes the profiling counters, writes
//                       them to the log buffer over AXI, then clears them. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module log_flush_sequencer
  import profcounter_pkg::*;
#(
  parameter int NUM_COUNTERS = 8,
  parameter int IDX_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [63:0]               offset,
  output logic                      done,
  output logic                      ready,
  output logic                      idle,
  input  logic [32*NUM_COUNTERS-1:0] cntVal,
  output logic                      cntFreeze,
  output logic                      cntClear,
  output logic                      err,
  log_flush_sequencer_if.master     axi
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COUNTERS - 1);

  logic [1:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [63:0]          base_q, base_d;
  logic                 err_q, err_d;

  logic      go;
  logic      issued;
  logic      resp;
  logic      resp_err;
  logic      accept;
  logic [31:0] word_data;
  log_word_t word;

  assign accept = (state_q == S_IDLE) & start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    err_d   = err_q;
    go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = offset;
          idx_d   = '0;
          err_d   = 1'b0;
          go      = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issued) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp) begin
          if (resp_err) err_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            go      = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The word is built from the next-state index so it is captured on the
  // same edge that enters S_ISSUE and then held by the write engine.
  always_comb begin
    word_data = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (idx_d == IDX_WIDTH'(i)) word_data = cntVal[32*i +: 32];
    end
  end

  always_comb begin
    word      = '0;
    word.addr = word_addr(base_d, 64'(idx_d));
    word.data = word_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  axi_single_write u_wr (
    .clk        (clk),
    .rst        (rst),
    .go_i       (go),
    .word_i     (word),
    .issued_o   (issued),
    .resp_o     (resp),
    .resp_err_o (resp_err),
    .axi        (axi)
  );

  assign idle      = (state_q == S_IDLE);
  assign ready     = accept;
  assign done      = (state_q == S_DONE);
  assign cntClear  = (state_q == S_DONE);
  assign cntFreeze = (state_q == S_ISSUE) | (state_q == S_RESP);
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_log_flush_sequencer.sv
// ----------------------------------------------------------------------------
// tb_log_flush_sequencer : directed self-checking bench with a small AXI
//                          write-slave model (configurable AW/W stalls, BRESP). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_log_flush_sequencer;

  localparam int NUM  = 4;
  localparam int IDXW = 2;

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              start  = 1'b0;
  logic [63:0]       offset = '0;
  logic [32*NUM-1:0] cntVal = '0;
  logic done, ready, idle, cntFreeze, cntClear, err;

  int checks = 0;
  int errors = 0;

  // slave model configuration (written by the stimulus only)
  int aw_delay    = 0;
  int w_delay     = 0;
  int err_b_index = -1;

  // slave model state (written by the slave process only)
  int          aw_n = 0, w_n = 0, b_issued = 0, b_hs = 0;
  int          aw_wait = 0, w_wait = 0, slv_min = 0;
  int          awv_cycles = 0, wv_cycles = 0, stab_err = 0;
  bit          b_pend = 0, awv_prev = 0, wv_prev = 0;
  logic [63:0] aw_prev = '0;
  logic [31:0] w_prev  = '0;
  logic [63:0] aw_log[$];
  logic [31:0] w_log[$];
  int          ready_cnt = 0, done_cnt = 0;

  log_flush_sequencer_if axi_if ();

  log_flush_sequencer #(
    .NUM_COUNTERS (NUM),
    .IDX_WIDTH    (IDXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .offset    (offset),
    .done      (done),
    .ready     (ready),
    .idle      (idle),
    .cntVal    (cntVal),
    .cntFreeze (cntFreeze),
    .cntClear  (cntClear),
    .err       (err),
    .axi       (axi_if.master)
  );

  always #5 clk = ~clk;

  // Slave responds on the falling edge so its outputs are stable at the next rising edge.
  always @(negedge clk) begin
    slv_min = (aw_n < w_n) ? aw_n : w_n;
    if (rst) begin
      axi_if.axiAWREADY = 1'b0;
      axi_if.axiWREADY  = 1'b0;
      axi_if.axiBVALID  = 1'b0;
      axi_if.axiBRESP   = 2'b00;
      b_pend   = 0;
      aw_wait  = 0;
      w_wait   = 0;
      awv_prev = 0;
      wv_prev  = 0;
      b_issued = slv_min;
    end else begin
      if (b_pend) begin
        axi_if.axiBVALID = 1'b0;
        b_pend = 0;
      end
      if (axi_if.axiBVALID !== 1'b1 && b_issued < slv_min) begin
        axi_if.axiBVALID = 1'b1;
        axi_if.axiBRESP  = (b_issued == err_b_index) ? 2'b10 : 2'b00;
        b_issued++;
      end
      if (axi_if.axiBVALID === 1'b1 && axi_if.axiBREADY === 1'b1) begin
        b_pend = 1;
        b_hs++;
      end
      if (axi_if.axiAWVALID === 1'b1) begin
        if (awv_prev && axi_if.axiAWADDR !== aw_prev) stab_err++;
        awv_cycles++;
        if (aw_wait >= aw_delay) begin
          axi_if.axiAWREADY = 1'b1;
          aw_log.push_back(axi_if.axiAWADDR);
          aw_n++;
          aw_wait = 0;
        end else begin
          axi_if.axiAWREADY = 1'b0;
          aw_wait++;
        end
      end else begin
        axi_if.axiAWREADY = 1'b0;
        aw_wait = 0;
      end
      awv_prev = (axi_if.axiAWVALID === 1'b1) && (axi_if.axiAWREADY !== 1'b1);
      aw_prev  = axi_if.axiAWADDR;
      if (axi_if.axiWVALID === 1'b1) begin
        if (wv_prev && axi_if.axiWDATA !== w_prev) stab_err++;
        wv_cycles++;
        if (w_wait >= w_delay) begin
          axi_if.axiWREADY = 1'b1;
          w_log.push_back(axi_if.axiWDATA);
          w_n++;
          w_wait = 0;
        end else begin
          axi_if.axiWREADY = 1'b0;
          w_wait++;
        end
      end else begin
        axi_if.axiWREADY = 1'b0;
        w_wait = 0;
      end
      wv_prev = (axi_if.axiWVALID === 1'b1) && (axi_if.axiWREADY !== 1'b1);
      w_prev  = axi_if.axiWDATA;
    end
  end

  always @(negedge clk) begin
    if (ready === 1'b1) ready_cnt++;
    if (done === 1'b1)  done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic [63:0] off, input logic [32*NUM-1:0] vals, input bit keep);
    offset = off;
    cntVal = vals;
    start  = 1'b1;
    #1;
    check("ready_at_accept", 64'(ready), 64'd1);
    step();
    check("freeze_in_run", 64'(cntFreeze), 64'd1);
    check("err_clear_on_accept", 64'(err), 64'd0);
    if (!keep) start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_writes(input int a0, input int w0, input logic [63:0] base,
                              input logic [32*NUM-1:0] vals);
    check("aw_count", 64'(aw_log.size() - a0), 64'd4);
    check("w_count", 64'(w_log.size() - w0), 64'd4);
    for (int i = 0; i < NUM; i++) begin
      if (a0 + i < aw_log.size()) check("aw_addr", aw_log[a0+i], base + 64'(4*i));
      if (w0 + i < w_log.size())  check("w_data", 64'(w_log[w0+i]), 64'(vals[32*i +: 32]));
    end
  endtask

  initial begin
    int lat, a0, w0, b0, avc0, wvc0, se0, rc0, dc0;
    bit found;
    logic [32*NUM-1:0] v;

    // reset state
    step();
    step();
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_freeze", 64'(cntFreeze), 64'd0);
    check("rst_clear", 64'(cntClear), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_awvalid", 64'(axi_if.axiAWVALID), 64'd0);
    check("rst_wvalid", 64'(axi_if.axiWVALID), 64'd0);
    check("rst_bready", 64'(axi_if.axiBREADY), 64'd0);
    check("rst_awaddr", axi_if.axiAWADDR, 64'd0);
    check("rst_wdata", 64'(axi_if.axiWDATA), 64'd0);
    rst = 1'b0;
    step();

    // basic run, zero-wait slave
    v  = {32'd4, 32'd3, 32'd2, 32'd1};
    a0 = aw_log.size(); w0 = w_log.size(); b0 = b_hs;
    start_run(64'h1000, v, 1'b0);
    check("wstrb", 64'(axi_if.axiWSTRB), 64'hF);
    wait_done(lat);
    check("t1_latency", 64'(lat), 64'd9);
    check("t1_clear_with_done", 64'(cntClear), 64'd1);
    check("t1_freeze_dropped", 64'(cntFreeze), 64'd0);
    step();
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_clear_pulse", 64'(cntClear), 64'd0);
    check("t1_idle", 64'(idle), 64'd1);
    check("t1_err", 64'(err), 64'd0);
    check("t1_b_count", 64'(b_hs - b0), 64'd4);
    check("t1_w0", 64'(w_log[w0]), 64'd1);
    check_writes(a0, w0, 64'h1000, v);

    // AWREADY stalled 3 cycles, WREADY immediate
    aw_delay = 3;
    v    = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    a0   = aw_log.size(); w0 = w_log.size(); b0 = b_hs;
    avc0 = awv_cycles; wvc0 = wv_cycles; se0 = stab_err;
    start_run(64'h4000, v, 1'b0);
    wait_done(lat);
    check("t2_latency", 64'(lat), 64'd21);
    step();
    check("t2_wvalid_cycles", 64'(wv_cycles - wvc0), 64'd4);
    check("t2_awvalid_cycles", 64'(awv_cycles - avc0), 64'd16);
    check("t2_stable", 64'(stab_err - se0), 64'd0);
    check("t2_b_count", 64'(b_hs - b0), 64'd4);
    check_writes(a0, w0, 64'h4000, v);

    // address wrap, WREADY stalled 2 cycles instead
    aw_delay = 0;
    w_delay  = 2;
    v  = {32'h44, 32'h33, 32'h22, 32'h11};
    a0 = aw_log.size(); w0 = w_log.size(); se0 = stab_err;
    start_run(64'hFFFF_FFFF_FFFF_FFF8, v, 1'b0);
    wait_done(lat);
    check("t3_latency", 64'(lat), 64'd17);
    step();
    check("t3_stable", 64'(stab_err - se0), 64'd0);
    check("t3_addr0", aw_log[a0], 64'hFFFF_FFFF_FFFF_FFF8);
    check("t3_addr1", aw_log[a0+1], 64'hFFFF_FFFF_FFFF_FFFC);
    check("t3_addr2", aw_log[a0+2], 64'h0);
    check("t3_addr3", aw_log[a0+3], 64'h4);
    check_writes(a0, w0, 64'hFFFF_FFFF_FFFF_FFF8, v);

    // SLVERR on word 1 only
    w_delay     = 0;
    err_b_index = b_issued + 1;
    v  = {32'd8, 32'd7, 32'd6, 32'd5};
    a0 = aw_log.size(); w0 = w_log.size(); b0 = b_hs;
    start_run(64'h3000, v, 1'b0);
    wait_done(lat);
    check("t4_latency", 64'(lat), 64'd9);
    step();
    check("t4_err_sticky", 64'(err), 64'd1);
    check("t4_b_count", 64'(b_hs - b0), 64'd4);
    check_writes(a0, w0, 64'h3000, v);
    err_b_index = -1;

    // start held across done: auto-restart, err cleared by the new accept
    v  = {32'd12, 32'd11, 32'd10, 32'd9};
    a0 = aw_log.size();
    start_run(64'h5000, v, 1'b1);
    wait_done(lat);
    check("t5_latency", 64'(lat), 64'd9);
    step();
    check("t5_restart_ready", 64'(ready), 64'd1);
    step();
    start = 1'b0;
    check("t5_err_after_restart", 64'(err), 64'd0);
    rc0 = ready_cnt; dc0 = done_cnt;
    for (int k = 0; k < 40; k++) step();
    check("t5_second_done", 64'(done_cnt - dc0), 64'd1);
    check("t5_no_extra_accept", 64'(ready_cnt - rc0), 64'd0);
    check("t5_total_writes", 64'(aw_log.size() - a0), 64'd8);
    check("t5_idle", 64'(idle), 64'd1);

    // async reset during word 2 response phase
    v  = {32'd40, 32'd30, 32'd20, 32'd10};
    a0 = aw_log.size();
    start_run(64'h2000, v, 1'b0);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (axi_if.axiBREADY === 1'b1 && (aw_n - a0) == 3) found = 1;
      else step();
    end
    check("t6_reached_word2_resp", 64'(found), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_awvalid", 64'(axi_if.axiAWVALID), 64'd0);
    check("t6_wvalid", 64'(axi_if.axiWVALID), 64'd0);
    check("t6_bready", 64'(axi_if.axiBREADY), 64'd0);
    check("t6_awaddr", axi_if.axiAWADDR, 64'd0);
    check("t6_wdata", 64'(axi_if.axiWDATA), 64'd0);
    check("t6_freeze", 64'(cntFreeze), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_clear", 64'(cntClear), 64'd0);
    check("t6_ready", 64'(ready), 64'd0);
    check("t6_err", 64'(err), 64'd0);
    check("t6_idle", 64'(idle), 64'd1);
    step();
    step();
    rst = 1'b0;
    step();
    a0 = aw_log.size(); w0 = w_log.size();
    start_run(64'h2000, v, 1'b0);
    wait_done(lat);
    check("t6_latency", 64'(lat), 64'd9);
    step();
    check("t6_first_addr", aw_log[a0], 64'h2000);
    check("t6_first_data", 64'(w_log[w0]), 64'd10);
    check_writes(a0, w0, 64'h2000, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
